// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the IF-stage sequencing logic: FSM state encoding
// and the instruction word injected as a bubble into IF/ID.
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN           = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT      = 2'd1;
  localparam logic [1:0] ST_REDIRECT_PEND = 2'd2;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/fetch_controller_if.sv
// Bundle between the fetch controller and the IF/ID/EX datapath it steers.
interface fetch_controller_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);

  // imem_req/imem_ready: a fetch is outstanding every cycle imem_req=1 and
  // completes in the cycle imem_ready=1; redirect_valid qualifies redirect_pc
  // for that same cycle only (no back-pressure, no holding required).
  logic             PCSrc_E;
  logic [XLEN-1:0]  PC_Target_E;
  logic             load_use_hazard;
  logic             imem_ready;
  logic             imem_req;
  logic             PCWrite;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             fetch_timeout;

  modport master (
    input  PCSrc_E, PC_Target_E, load_use_hazard, imem_ready,
    output imem_req, PCWrite, redirect_valid, redirect_pc,
           IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
           stall_count, flush_count, fetch_timeout
  );

  modport slave (
    output PCSrc_E, PC_Target_E, load_use_hazard, imem_ready,
    input  imem_req, PCWrite, redirect_valid, redirect_pc,
           IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
           stall_count, flush_count, fetch_timeout
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: arbitrates EX redirects, load-use stalls and imem wait
// states into PC/IF-ID/ID-EX controls, with perf counters and a watchdog.
module fetch_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  fetch_controller_if.master  bus,
  output logic [1:0]          dbg_state_o
);

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  logic [1:0]      state_q, state_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            pend_redir_q, pend_redir_d;
  logic            timeout_q, timeout_d;

  logic            imem_req, pc_write, redir_valid, if_id_write, if_id_flush, id_ex_flush;
  logic [XLEN-1:0] redir_pc;

  always_comb begin
    imem_req      = 1'b0;
    pc_write      = 1'b0;
    redir_valid   = 1'b0;
    redir_pc      = '0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = '0;
    pend_target_d = pend_target_q;
    pend_redir_d  = pend_redir_q;

    if (!reset) begin
      state_d       = ST_RUN;
      pend_target_d = '0;
      pend_redir_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          imem_req = 1'b1;
          // A redirect deferred from a wait state outranks everything, even a new PCSrc_E.
          if (pend_redir_q || bus.PCSrc_E) begin
            redir_valid  = 1'b1;
            redir_pc     = pend_redir_q ? pend_target_q : bus.PC_Target_E;
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            pend_redir_d = 1'b0;
          end else if (bus.load_use_hazard) begin
            id_ex_flush = 1'b1;
          end else if (bus.imem_ready) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end else begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            state_d     = ST_MEM_WAIT;
            wait_cnt_d  = 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          imem_req = 1'b1;
          if (bus.PCSrc_E) begin
            pend_target_d = bus.PC_Target_E;
            if_id_write   = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            if (bus.imem_ready) begin
              state_d      = ST_RUN;
              pend_redir_d = 1'b1;
            end else begin
              state_d = ST_REDIRECT_PEND;
            end
          end else if (bus.load_use_hazard) begin
            id_ex_flush = 1'b1;
            wait_cnt_d  = wait_cnt_q;
          end else if (bus.imem_ready) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            state_d     = ST_RUN;
          end else begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            wait_cnt_d  = (wait_cnt_q >= MAX_W8) ? MAX_W8 : wait_cnt_q + 8'd1;
          end
        end
        ST_REDIRECT_PEND: begin
          // The word returned here belongs to the squashed path and is dropped.
          imem_req    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          if (bus.imem_ready) begin
            state_d      = ST_RUN;
            pend_redir_d = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    timeout_d = reset & (timeout_q | (wait_cnt_d == MAX_W8));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      pend_target_q <= '0;
      pend_redir_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pend_target_q <= pend_target_d;
      pend_redir_q  <= pend_redir_d;
      timeout_q     <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (~pc_write),
    .count_o (bus.stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (redir_valid),
    .count_o (bus.flush_count)
  );

  assign bus.imem_req       = imem_req;
  assign bus.PCWrite        = pc_write;
  assign bus.redirect_valid = redir_valid;
  assign bus.redirect_pc    = redir_pc;
  assign bus.IF_ID_Write    = if_id_write;
  assign bus.IF_ID_Flush    = if_id_flush;
  assign bus.ID_EX_Flush    = id_ex_flush;
  assign bus.fetch_timeout  = timeout_q;
  assign dbg_state_o        = state_q;

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequencing controller for the IF stage and the IF/ID and ID/EX pipeline registers.
- Arbitrates between three sources: EX-stage redirects (PCSrc_E), the decode load-use hazard, and instruction-memory wait states.
- Drives PCWrite, IF/ID write and flush, ID/EX flush, and the redirect PC into IF.
- Keeps stall and flush performance counters and a fetch-timeout watchdog.

Parameters:
XLEN, 64, PC and target width
CNT_W, 32, width of the saturating performance counters
MAX_WAIT, 16, MEM_WAIT cycles before fetch_timeout sets (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (sampled on rising clk)
PCSrc_E  input  1  EX resolved a taken branch or mispredict; redirect required
PC_Target_E  input  XLEN  redirect target, valid with PCSrc_E
load_use_hazard  input  1  decode-stage load-use hazard
imem_ready  input  1  instruction memory returns the requested word this cycle
imem_req  output  1  fetch request to instruction memory
PCWrite  output  1  PC register update enable
redirect_valid  output  1  IF selects redirect_pc as next PC
redirect_pc  output  XLEN  next-PC override
IF_ID_Write  output  1  IF/ID register load enable
IF_ID_Flush  output  1  load NOP into IF/ID
ID_EX_Flush  output  1  load bubble into ID/EX
stall_count  output  CNT_W  cycles with PCWrite=0, saturating
flush_count  output  CNT_W  redirects issued, saturating
fetch_timeout  output  1  sticky: a MEM_WAIT lasted >= MAX_WAIT cycles

Behaviour:
Reset (reset=0 at rising edge):
- state=RUN, counters=0, fetch_timeout=0, pending target=0, wait counter=0.
- While reset=0, all control outputs are 0 (imem_req, PCWrite, redirect_valid, IF_ID_Write, IF_ID_Flush, ID_EX_Flush) and redirect_pc=0.
- Reset mid-WAIT or mid-REDIRECT_PEND discards the pending target and returns to RUN.

Output timing:
- Control outputs are Mealy: combinational from state and the current inputs.
- State and counters are registered.

State machine (states RUN, MEM_WAIT, REDIRECT_PEND):
- RUN: imem_req=1. Priority is PCSrc_E > load_use_hazard > imem miss.
  - PCSrc_E=1: redirect_valid=1, redirect_pc=PC_Target_E, PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1, IF_ID_Write=1. Zero-latency redirect; flush_count+1. Applies regardless of imem_ready; stay in RUN.
  - Else load_use_hazard=1: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. Stay in RUN, even if imem_ready=0; the fetch is re-issued.
  - Else imem_ready=1: PCWrite=1, IF_ID_Write=1, no flushes.
  - Else (imem_ready=0): PCWrite=0, IF_ID_Write=1, IF_ID_Flush=1 (NOP injected). Go to MEM_WAIT with wait counter=1.
- MEM_WAIT: imem_req=1 held. Same priority as RUN, except PCSrc_E does not redirect here:
  - PCSrc_E=1: latch PC_Target_E as the pending target; IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=0. If imem_ready=1 this cycle, go to RUN and issue the redirect next cycle from the pending target. Otherwise go to REDIRECT_PEND.
  - Else load_use_hazard=1: IF_ID_Write=0, no IF_ID_Flush, ID_EX_Flush=1, PCWrite=0. Stay in MEM_WAIT.
  - Else imem_ready=1: PCWrite=1, IF_ID_Write=1. Go to RUN.
  - Else: inject NOP as in RUN; wait counter+1, saturating at MAX_WAIT.
- REDIRECT_PEND: imem_req=1; PCWrite=0; IF_ID_Flush=1. Further PCSrc_E are ignored, since younger instructions are already flushed. On imem_ready=1 the returned word is discarded; go to RUN.
- First RUN cycle after a pending redirect: the redirect uses the latched target (redirect_valid=1, PCWrite=1, IF_ID_Flush=1); flush_count+1. A coincident PCSrc_E is ignored that cycle.

Counters and flags:
- stall_count +1 every non-reset cycle with PCWrite=0.
- Counters saturate at 2^CNT_W-1.
- fetch_timeout sets when the wait counter reaches MAX_WAIT and holds until reset.

Decomposition:
- Shared package pipeline_ctrl_pkg: state encoding (RUN=2'd0, MEM_WAIT=2'd1, REDIRECT_PEND=2'd2) and a NOP constant (32'h00000013).
- One sub-module, sat_counter: parameterized width, synchronous active-low reset, increment enable. Instantiated twice (stall_count, flush_count).

Test Plan:
1. Reset low 2 cycles, then high; imem_ready=1 throughout -> all control outputs 0 during reset; afterwards PCWrite=1, IF_ID_Write=1, stall_count stays 0.
2. In RUN, PCSrc_E=1 with PC_Target_E=64'h10 for 1 cycle -> same cycle: redirect_valid=1, redirect_pc=64'h10, IF_ID_Flush=1, ID_EX_Flush=1; flush_count=1.
3. load_use_hazard=1 for 1 cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; stall_count=1.
4. imem_ready=0 for 3 cycles, PCSrc_E=1 with PC_Target_E=64'h40 in the 2nd wait cycle -> PCWrite=0 for 3 cycles; state is REDIRECT_PEND after the 2nd cycle. On the cycle after imem_ready returns: redirect_valid=1, redirect_pc=64'h40.
5. PCSrc_E=1 and load_use_hazard=1 in the same RUN cycle -> redirect wins; PCWrite=1, ID_EX_Flush=1.
6. MAX_WAIT=4, imem_ready=0 for 5 cycles -> fetch_timeout=1 from the 4th wait cycle, still 1 after recovery; pulsing reset low mid-wait clears it and returns to RUN.
